fetch_stage: RTL

Instruction-fetch stage directly upstream of the decode/immediate-generation logic. It owns the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency. Returned words go into a 2-entry buffer, and the stage presents {instr, pc, pc+4} to decode with a valid/ready handshake. A redirect from the branch/jump resolution logic flushes all stale fetches and restarts fetch at the new target.

---
 rtl/fetch_stage.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle-latency instruction memory,
// buffers returned words in a 2-entry FIFO and hands {instr, pc, pc+4} to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               CLK,
  input  logic               RST_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4
);

  logic [31:0] pc;
  logic        inflight;
  logic [31:0] inflight_pc;

  logic [31:0] buf_instr [2];
  logic [31:0] buf_pc    [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        buf_empty;
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;

  assign buf_empty = (count == 2'd0);
  assign pop       = id_valid & id_ready;
  assign push      = inflight & ~redirect_valid;

  // Entries held plus the word already on its way, less the one leaving now;
  // a new request is only allowed if its data is guaranteed a free slot.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = RST_n & ~redirect_valid & (occupancy <= 3'd1);

  assign imem_req  = issue;
  assign imem_addr = pc[IMEM_AW+1:2];

  assign id_valid  = ~buf_empty & ~redirect_valid;
  assign id_instr  = buf_empty ? NOP_INSTR : buf_instr[rd_ptr];
  assign id_pc     = buf_empty ? pc : buf_pc[rd_ptr];
  assign id_pc4    = id_pc + 32'd4;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~32'd3;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_valid) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: count gates every read of it.
  always_ff @(posedge CLK) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= inflight_pc;
    end
  end

  a_no_push_when_full: assert property (@(posedge CLK) disable iff (!RST_n)
    !(push && count == 2'd2));

endmodule
